// File: rtl/int_alu_pkg.sv
// Shared definitions for the integer ALU blocks (adder and subtractor):
// default operand width and the bit ordering of the registered flag vector.
package int_alu_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Flag vector bit positions; the adder uses the same slots (carry/borrow share slot 0).
  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ZERO     = 2;
  localparam int unsigned FLAG_W        = 3;

  typedef logic [FLAG_W-1:0] flags_t;

  // Assemble a flag vector in the shared bit order.
  function automatic flags_t pack_flags(input logic carry, input logic ovf, input logic zero);
    flags_t f;
    f                = '0;
    f[FLAG_CARRY]    = carry;
    f[FLAG_OVERFLOW] = ovf;
    f[FLAG_ZERO]     = zero;
    return f;
  endfunction

endpackage

// File: rtl/int_subtractor_fs.sv
// Single-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/int_subtractor.sv
// Two-stage pipelined subtractor with valid/ready handshake and global enable.
// Stage 1 resolves the low half and forwards the high operand halves plus the
// intermediate borrow; stage 2 resolves the high half and all flags.
module int_subtractor
  import int_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  borrow_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow_out,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned HALF = DATA_WIDTH / 2;

  if ((DATA_WIDTH % 2 != 0) || (DATA_WIDTH < 4)) begin : g_bad_width
    $error("int_subtractor: DATA_WIDTH must be even and >= 4");
  end

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_advance;
  logic accept;
  logic move;

  // Output register can take a new entry when empty or being consumed.
  assign s2_advance = ~out_valid_q | out_ready;
  // rst_n gates in_ready so nothing is offered while reset is held.
  assign in_ready   = rst_n & en & (~s1_valid_q | s2_advance);
  assign accept     = in_valid & in_ready;
  assign move       = en & s2_advance;

  // ---------------------------------------------------------------------------
  // Stage 1: low-half subtraction
  // ---------------------------------------------------------------------------
  logic [HALF:0]   lo_borrow;
  logic [HALF-1:0] lo_diff;

  assign lo_borrow[0] = borrow_in;

  for (genvar i = 0; i < HALF; i++) begin : g_lo
    fs u_fs (
      .a         (data_a[i]),
      .b         (data_b[i]),
      .borrow_in (lo_borrow[i]),
      .diff      (lo_diff[i]),
      .borrow_out(lo_borrow[i+1])
    );
  end

  logic [HALF-1:0] s1_diff_lo_q;
  logic [HALF-1:0] s1_a_hi_q;
  logic [HALF-1:0] s1_b_hi_q;
  logic            s1_borrow_q;

  // ---------------------------------------------------------------------------
  // Stage 2: high-half subtraction and flags, from stage-1 registers
  // ---------------------------------------------------------------------------
  logic [HALF:0]   hi_borrow;
  logic [HALF-1:0] hi_diff;

  assign hi_borrow[0] = s1_borrow_q;

  for (genvar i = 0; i < HALF; i++) begin : g_hi
    fs u_fs (
      .a         (s1_a_hi_q[i]),
      .b         (s1_b_hi_q[i]),
      .borrow_in (hi_borrow[i]),
      .diff      (hi_diff[i]),
      .borrow_out(hi_borrow[i+1])
    );
  end

  logic [DATA_WIDTH-1:0] diff_d, diff_q;
  logic                  ovf_d;
  logic                  zero_d;
  flags_t                flags_d, flags_q;

  // Resolve the full difference and derive the flags from it.
  always_comb begin
    diff_d  = {hi_diff, s1_diff_lo_q};
    // Signed overflow: operand signs differ and result sign differs from minuend.
    ovf_d   = (s1_a_hi_q[HALF-1] != s1_b_hi_q[HALF-1]) && (hi_diff[HALF-1] != s1_a_hi_q[HALF-1]);
    zero_d  = (diff_d == '0);
    flags_d = pack_flags(hi_borrow[HALF], ovf_d, zero_d);
  end

  // Occupancy next state: stage 1 fills on accept and drains when it moves on;
  // the output slot takes whatever stage 1 holds whenever it advances.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (move) begin
      s1_valid_d = 1'b0;
    end
    if (move) begin
      out_valid_d = s1_valid_q;
    end
  end

  // Valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Stage-1 data registers, loaded only on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_diff_lo_q <= '0;
      s1_a_hi_q    <= '0;
      s1_b_hi_q    <= '0;
      s1_borrow_q  <= 1'b0;
    end else if (accept) begin
      s1_diff_lo_q <= lo_diff;
      s1_a_hi_q    <= data_a[DATA_WIDTH-1:HALF];
      s1_b_hi_q    <= data_b[DATA_WIDTH-1:HALF];
      s1_borrow_q  <= lo_borrow[HALF];
    end
  end

  // Result registers, loaded only when a valid stage-1 entry moves forward so
  // data and flags stay frozen while the output is stalled or en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q  <= '0;
      flags_q <= '0;
    end else if (move && s1_valid_q) begin
      diff_q  <= diff_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign diff       = diff_q;
  assign borrow_out = flags_q[FLAG_CARRY];
  assign overflow   = flags_q[FLAG_OVERFLOW];
  assign zero       = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_int_subtractor.sv
// Self-checking bench for int_subtractor (DATA_WIDTH = 32): directed vectors,
// stall / enable / reset scenarios and a randomized stream against a queue model.
module tb_int_subtractor;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int_subtractor #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .borrow_in (borrow_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic        o;
    logic        z;
  } res_t;

  res_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_consumed = 0;
  bit          hold_valid = 0;
  logic [31:0] prev_diff;
  logic [2:0]  prev_flags;
  logic        last_in_ready;

  // Reference: plain wide arithmetic on the operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t        r;
    logic [32:0] w;
    w   = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    r.d = w[31:0];
    r.b = w[32];
    r.o = (a[31] != b[31]) && (r.d[31] != a[31]);
    r.z = (r.d == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake/holding rules, score consumed results, record accepts.
  task automatic tick(output bit acc);
    bit   cons;
    res_t e;
    #1;
    chk("in_ready", in_ready, rst_n & en & ((q.size() < 2) | out_ready));
    if (q.size() == 0) chk("idle_out_valid", out_valid, 0);
    if (hold_valid) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_diff", diff, prev_diff);
      chk("hold_flags", {borrow_out, overflow, zero}, prev_flags);
    end
    last_in_ready = in_ready;
    cons = en & out_valid & out_ready;
    acc  = in_valid & in_ready;
    if (cons) begin
      if (q.size() == 0) begin
        chk("spurious_result", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("diff", diff, e.d);
        chk("borrow_out", borrow_out, e.b);
        chk("overflow", overflow, e.o);
        chk("zero", zero, e.z);
        n_consumed++;
      end
    end
    if (acc) q.push_back(model(data_a, data_b, borrow_in));
    hold_valid = out_valid & ~cons;
    prev_diff  = diff;
    prev_flags = {borrow_out, overflow, zero};
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one operation until accepted (bounded), then drop in_valid.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic bin);
    bit acc;
    acc       = 0;
    data_a    = a;
    data_b    = b;
    borrow_in = bin;
    in_valid  = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    chk("op_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick(acc);
    chk("drain_empty", q.size(), 0);
  endtask

  // Isolated operation with fixed expected values and latency check.
  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
    bit acc;
    en        = 1'b1;
    out_ready = 1'b1;
    op(a, b, bin);
    chk("lat_1cyc_out_valid", out_valid, 0);
    tick(acc);
    chk("lat_2cyc_out_valid", out_valid, 1);
    chk("vec_diff", diff, ed);
    chk("vec_borrow_out", borrow_out, eb);
    chk("vec_overflow", overflow, eo);
    chk("vec_zero", zero, ez);
    drain();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [7];
    specials = '{32'h0, 32'h1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                 32'h0000_FFFF, 32'h0001_0000};
    if ($urandom_range(0, 9) < 7) return $urandom;
    return specials[$urandom_range(0, 6)];
  endfunction

  initial begin
    bit acc;
    bit saw_stall;
    int sent;
    int base;

    rst_n     = 1'b0;
    en        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_a    = '0;
    data_b    = '0;
    borrow_in = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {borrow_out, overflow, zero}, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors.
    single(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    single(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    single(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    single(32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    single(32'd7, 32'd7, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // 8 back-to-back operations with the consumer stalled for 3 cycles.
    base      = n_consumed;
    sent      = 0;
    saw_stall = 0;
    en        = 1'b1;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      in_valid  = 1'b1;
      data_a    = 32'h100 * (sent + 1);
      data_b    = 32'h11 * (sent + 3);
      borrow_in = sent[0];
      out_ready = !(c >= 3 && c <= 5);
      tick(acc);
      if (!last_in_ready) saw_stall = 1;
      if (acc) sent++;
    end
    chk("b2b_sent", sent, 8);
    chk("b2b_in_ready_dropped", saw_stall, 1);
    drain();
    chk("b2b_count", n_consumed - base, 8);

    // en low for 2 cycles with both stages full and consumer ready.
    base      = n_consumed;
    out_ready = 1'b0;
    op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    op(32'h0000_0010, 32'h0000_0020, 1'b1);
    chk("en_full_out_valid", out_valid, 1);
    en        = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_a    = 32'h5555_5555;
    repeat (2) tick(acc);
    chk("en_low_out_valid", out_valid, 1);
    in_valid = 1'b0;
    drain();
    chk("en_resume_count", n_consumed - base, 2);

    // Reset with both stages full.
    out_ready = 1'b0;
    en        = 1'b1;
    op(32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    op(32'h0000_0003, 32'h0000_0009, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_flags", {borrow_out, overflow, zero}, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    hold_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick(acc);
    single(32'd100, 32'd1, 1'b1, 32'd98, 1'b0, 1'b0, 1'b0);

    // Randomized stream.
    for (int c = 0; c < 500; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      data_a    = rand_operand();
      data_b    = rand_operand();
      borrow_in = $urandom_range(0, 1);
      tick(acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
